// File: rtl/asrm_bus_fifo_port_pkg.sv
// rtl/asrm_bus_fifo_port_pkg.sv - register offsets and STATUS bit indices for the ASRM bus FIFO port
package asrm_bus_fifo_port_pkg;

  // Word offsets inside the 4-word window
  localparam logic [1:0] asrm_fp_tx_data = 2'd0;
  localparam logic [1:0] asrm_fp_rx_data = 2'd1;
  localparam logic [1:0] asrm_fp_rx_pop  = 2'd2;
  localparam logic [1:0] asrm_fp_status  = 2'd3;

  // STATUS register bit positions
  localparam int st_tx_full      = 0;
  localparam int st_tx_empty     = 1;
  localparam int st_rx_full      = 2;
  localparam int st_rx_empty     = 3;
  localparam int st_tx_overflow  = 4;
  localparam int st_rx_underflow = 5;
  localparam int st_ie_lo        = 8;
  localparam int st_ie_hi        = 10;

endpackage

// File: rtl/asrm_sync_fifo.sv
// rtl/asrm_sync_fifo.sv - single-clock FIFO with combinational head, self-guarding push/pop
module asrm_sync_fifo #(
  parameter int wordsize = 16,
  parameter int depth    = 8,
  localparam int aw      = $clog2(depth)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [wordsize-1:0] push_data,
  input  logic                pop,
  output logic [wordsize-1:0] head,
  output logic                full,
  output logic                empty,
  output logic [aw:0]         count
);

  logic [wordsize-1:0] mem [depth];
  logic [aw-1:0]       wr_ptr;
  logic [aw-1:0]       rd_ptr;
  logic                do_push;
  logic                do_pop;

  // Requests are filtered here so callers may assert them blindly
  assign full    = (count == (aw+1)'(depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at depth (power of two); count tracks occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/asrm_bus_fifo_port.sv
// rtl/asrm_bus_fifo_port.sv - ASRM bus responder exposing TX/RX FIFOs (optional irq: ASRM_FIFO_PORT_IRQ_EN)
module asrm_bus_fifo_port
  import asrm_bus_fifo_port_pkg::*;
#(
  parameter int                  wordsize  = 16,
  parameter int                  depth     = 8,
  parameter logic [wordsize-1:0] base_addr = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] bus_addr,
  input  logic [wordsize-1:0] bus_wdata,
  input  logic                bus_write_en,
  output logic [wordsize-1:0] bus_rdata,
  output logic [wordsize-1:0] tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [wordsize-1:0] rx_data,
  input  logic                rx_valid,
`ifdef ASRM_FIFO_PORT_IRQ_EN
  output logic                irq,
`endif
  output logic                rx_ready
);

  localparam int aw = $clog2(depth);

  logic                hit;
  logic [1:0]          off;
  logic                we_q;
  logic                commit;
  logic                tx_push_req;
  logic                rx_pop_req;
  logic                status_wr;
  logic                tx_full, tx_empty, rx_full, rx_empty;
  logic [aw:0]         tx_count, rx_count;
  logic [wordsize-1:0] rx_head;
  logic                tx_overflow, rx_underflow;
  logic [wordsize-1:0] rd_next;
`ifdef ASRM_FIFO_PORT_IRQ_EN
  logic [2:0]          ie;
`endif

  assign hit = (bus_addr[wordsize-1:2] == base_addr[wordsize-1:2]);
  assign off = bus_addr[1:0];

  // Only the rising edge of the write strobe, inside the window, commits
  assign commit      = bus_write_en & ~we_q & hit;
  assign tx_push_req = commit & (off == asrm_fp_tx_data);
  assign rx_pop_req  = commit & (off == asrm_fp_rx_pop);
  assign status_wr   = commit & (off == asrm_fp_status);

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  asrm_sync_fifo #(.wordsize(wordsize), .depth(depth)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push_req),
    .push_data (bus_wdata),
    .pop       (tx_ready),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  asrm_sync_fifo #(.wordsize(wordsize), .depth(depth)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop_req),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // Write-edge register; tracks the strobe even for out-of-window writes
  always_ff @(posedge clk) begin
    if (!reset) we_q <= 1'b0;
    else        we_q <= bus_write_en;
  end

  // Sticky error flags (and interrupt enables) cleared/loaded by a STATUS write
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
`ifdef ASRM_FIFO_PORT_IRQ_EN
      ie           <= 3'b000;
`endif
    end else begin
      if (status_wr) begin
        tx_overflow  <= 1'b0;
        rx_underflow <= 1'b0;
`ifdef ASRM_FIFO_PORT_IRQ_EN
        ie           <= bus_wdata[st_ie_hi:st_ie_lo];
`endif
      end
      if (tx_push_req & tx_full)  tx_overflow  <= 1'b1;
      if (rx_pop_req  & rx_empty) rx_underflow <= 1'b1;
    end
  end

  // Read mux from pre-edge state; zero outside the window for OR-combining
  always_comb begin
    rd_next = '0;
    if (hit) begin
      case (off)
        asrm_fp_tx_data: rd_next[aw:0] = tx_count;
        asrm_fp_rx_data: rd_next       = rx_empty ? '0 : rx_head;
        asrm_fp_rx_pop:  rd_next[aw:0] = rx_count;
        default: begin
          rd_next[st_tx_full]      = tx_full;
          rd_next[st_tx_empty]     = tx_empty;
          rd_next[st_rx_full]      = rx_full;
          rd_next[st_rx_empty]     = rx_empty;
          rd_next[st_tx_overflow]  = tx_overflow;
          rd_next[st_rx_underflow] = rx_underflow;
`ifdef ASRM_FIFO_PORT_IRQ_EN
          rd_next[st_ie_hi:st_ie_lo] = ie;
`endif
        end
      endcase
    end
  end

  // Registered read data, one cycle behind bus_addr
  always_ff @(posedge clk) begin
    if (!reset) bus_rdata <= '0;
    else        bus_rdata <= rd_next;
  end

`ifdef ASRM_FIFO_PORT_IRQ_EN
  // Registered interrupt from the enabled status conditions
  always_ff @(posedge clk) begin
    if (!reset) irq <= 1'b0;
    else        irq <= (~rx_empty & ie[0]) | (tx_empty & ie[1]) |
                       ((tx_overflow | rx_underflow) & ie[2]);
  end
`endif

endmodule

// File: tb/tb_asrm_bus_fifo_port.sv
// tb/tb_asrm_bus_fifo_port.sv - queue-model bench for asrm_bus_fifo_port
module tb_asrm_bus_fifo_port;

  localparam int          DEPTH = 8;
  localparam logic [15:0] BASE  = 16'hFF00;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_write_en;
  logic [15:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
`ifdef ASRM_FIFO_PORT_IRQ_EN
  logic        irq;
`endif

  asrm_bus_fifo_port #(.wordsize(16), .depth(DEPTH), .base_addr(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_write_en (bus_write_en),
    .bus_rdata    (bus_rdata),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
`ifdef ASRM_FIFO_PORT_IRQ_EN
    .irq          (irq),
`endif
    .rx_ready     (rx_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit checking = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two queues, sticky flags, edge memory
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  bit          m_ovf, m_unf, m_we_prev, m_irq, m_hit, m_commit;
  logic [2:0]  m_ie;
  logic [15:0] exp_rdata;
  logic [1:0]  m_off;
  int          txn, rxn;

  function automatic logic [15:0] status_word(input int tn, input int rn);
    logic [15:0] s;
    s = '0;
    s[0] = (tn == DEPTH);
    s[1] = (tn == 0);
    s[2] = (rn == DEPTH);
    s[3] = (rn == 0);
    s[4] = m_ovf;
    s[5] = m_unf;
`ifdef ASRM_FIFO_PORT_IRQ_EN
    s[10:8] = m_ie;
`endif
    return s;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      tx_q.delete();
      rx_q.delete();
      m_ovf = 0; m_unf = 0; m_we_prev = 0; m_irq = 0; m_ie = '0;
      exp_rdata = '0;
    end else begin
      txn = tx_q.size();
      rxn = rx_q.size();
      m_hit = (bus_addr[15:2] == BASE[15:2]);
      m_off = bus_addr[1:0];
      if (!m_hit) exp_rdata = '0;
      else case (m_off)
        2'd0: exp_rdata = 16'(txn);
        2'd1: exp_rdata = (rxn != 0) ? rx_q[0] : 16'h0;
        2'd2: exp_rdata = 16'(rxn);
        default: exp_rdata = status_word(txn, rxn);
      endcase
      m_irq = ((rxn != 0) && m_ie[0]) || ((txn == 0) && m_ie[1]) || ((m_ovf || m_unf) && m_ie[2]);
      m_commit = bus_write_en && !m_we_prev && m_hit;
      m_we_prev = bus_write_en;
      if (txn > 0 && tx_ready) void'(tx_q.pop_front());
      if (rxn < DEPTH && rx_valid) rx_q.push_back(rx_data);
      if (m_commit) case (m_off)
        2'd0: if (txn == DEPTH) m_ovf = 1; else tx_q.push_back(bus_wdata);
        2'd2: if (rxn == 0) m_unf = 1; else void'(rx_q.pop_front());
        2'd3: begin
          m_ovf = 0; m_unf = 0;
`ifdef ASRM_FIFO_PORT_IRQ_EN
          m_ie = bus_wdata[10:8];
`endif
        end
        default: ;
      endcase
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
      if (tx_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(tx_q[0]));
      chk("rx_ready", 32'(rx_ready), 32'(rx_q.size() < DEPTH));
      chk("bus_rdata", 32'(bus_rdata), 32'(exp_rdata));
`ifdef ASRM_FIFO_PORT_IRQ_EN
      chk("irq", 32'(irq), 32'(m_irq));
`endif
    end
  end

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input int hold);
    bus_addr = a; bus_wdata = d; bus_write_en = 1'b1;
    repeat (hold) @(negedge clk);
    bus_write_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    bus_addr = a;
    @(negedge clk);
    d = bus_rdata;
  endtask

  task automatic rx_send(input logic [15:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  logic [15:0] rd;

  initial begin
    reset = 1'b0; bus_addr = '0; bus_wdata = '0; bus_write_en = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checking = 1;

    // Reset state
    bus_read(BASE + 16'd3, rd);
    chk("reset_status", 32'(rd), 32'h000A);
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("reset_rx_ready", 32'(rx_ready), 32'h1);

    // Held write strobe pushes exactly once
    bus_write(BASE, 16'h1234, 3);
    chk("held_push_valid", 32'(tx_valid), 32'h1);
    chk("held_push_data", 32'(tx_data), 32'h1234);
    bus_read(BASE, rd);
    chk("held_push_count", 32'(rd), 32'h1);
    tx_ready = 1'b1; @(negedge clk); tx_ready = 1'b0;
    chk("drain_one", 32'(tx_valid), 32'h0);

    // Overflow on the ninth push
    for (int i = 0; i < 9; i++) bus_write(BASE, 16'h0100 + 16'(i), 1);
    bus_read(BASE + 16'd3, rd);
    chk("overflow_status", 32'(rd), 32'h0019);
    bus_write(BASE + 16'd3, 16'h0000, 1);
    bus_read(BASE + 16'd3, rd);
    chk("overflow_cleared", 32'(rd), 32'h0009);
    chk("tx_head_first", 32'(tx_data), 32'h0100);
    tx_ready = 1'b1; repeat (8) @(negedge clk); tx_ready = 1'b0;
    chk("tx_drained", 32'(tx_valid), 32'h0);

    // RX path, pops and underflow
    rx_send(16'hAAAA);
    rx_send(16'h5555);
    bus_read(BASE + 16'd1, rd);
    chk("rx_head_a", 32'(rd), 32'hAAAA);
    bus_read(BASE + 16'd2, rd);
    chk("rx_count_2", 32'(rd), 32'h2);
    bus_write(BASE + 16'd2, 16'h0, 1);
    bus_read(BASE + 16'd1, rd);
    chk("rx_head_5", 32'(rd), 32'h5555);
    bus_write(BASE + 16'd2, 16'h0, 1);
    bus_read(BASE + 16'd1, rd);
    chk("rx_head_empty", 32'(rd), 32'h0);
    bus_write(BASE + 16'd2, 16'h0, 1);
    bus_read(BASE + 16'd3, rd);
    chk("underflow_status", 32'(rd), 32'h002A);
    bus_write(BASE + 16'd3, 16'h0, 1);

    // Window decode
    rx_send(16'hBEEF);
    bus_read(BASE + 16'd1, rd);
    chk("rx_head_beef", 32'(rd), 32'hBEEF);
    bus_read(BASE + 16'd4, rd);
    chk("miss_reads_zero", 32'(rd), 32'h0);
    bus_write(16'h0000, 16'h0077, 1);
    bus_read(BASE, rd);
    chk("miss_no_tx_push", 32'(rd), 32'h0);
    bus_read(BASE + 16'd2, rd);
    chk("miss_no_rx_pop", 32'(rd), 32'h1);
    bus_write(BASE + 16'd2, 16'h0, 1);

`ifdef ASRM_FIFO_PORT_IRQ_EN
    bus_write(BASE + 16'd3, 16'h0100, 1);
    rx_send(16'h0001);
    @(negedge clk);
    chk("irq_rx_set", 32'(irq), 32'h1);
    bus_write(BASE + 16'd2, 16'h0, 1);
    chk("irq_rx_clear", 32'(irq), 32'h0);
`endif

    // Randomized traffic with occasional mid-run resets
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 599) != 0);
      bus_addr     = ($urandom_range(0, 7) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 4));
      bus_write_en = ($urandom_range(0, 2) == 0);
      bus_wdata    = 16'($urandom);
      rx_data      = 16'($urandom);
      if (i < 2000) begin
        tx_ready = ($urandom_range(0, 3) == 0);
        rx_valid = ($urandom_range(0, 3) != 0);
      end else begin
        tx_ready = ($urandom_range(0, 3) != 0);
        rx_valid = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
    end

    reset = 1'b1; bus_write_en = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    checking = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
